// File: rtl/nx_msg_encoder.sv
`default_nettype none
// ============================================================================
// Module   : nx_msg_encoder
// Purpose  : Packs instruction-load, I/O-map and signal-state requests into
//            node-protocol messages. Selects the outbound direction by XY
//            routing and buffers messages in a 2-entry valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module nx_msg_encoder #(
   parameter int STREAM_WIDTH   = 32,
   parameter int ADDR_ROW_WIDTH = 4,
   parameter int ADDR_COL_WIDTH = 4,
   parameter int COMMAND_WIDTH  = 2,
   parameter int INSTR_WIDTH    = 15,
   parameter int INPUTS         = 8,
   parameter int OUTPUTS        = 8,
   localparam int IO_W  = $clog2((INPUTS > OUTPUTS) ? INPUTS : OUTPUTS),
   localparam int IDX_W = $clog2(OUTPUTS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
   input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
   input  logic [ADDR_ROW_WIDTH-1:0] tgt_row_i,
   input  logic [ADDR_COL_WIDTH-1:0] tgt_col_i,
   input  logic                      instr_core_i,
   input  logic [INSTR_WIDTH-1:0]    instr_data_i,
   input  logic                      instr_valid_i,
   output logic                      instr_ready_o,
   input  logic [IO_W-1:0]           map_io_i,
   input  logic                      map_input_i,
   input  logic [ADDR_ROW_WIDTH-1:0] map_remote_row_i,
   input  logic [ADDR_COL_WIDTH-1:0] map_remote_col_i,
   input  logic [IDX_W-1:0]          map_remote_idx_i,
   input  logic                      map_slot_i,
   input  logic                      map_broadcast_i,
   input  logic                      map_seq_i,
   input  logic                      map_valid_i,
   output logic                      map_ready_o,
   input  logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_i,
   input  logic [ADDR_COL_WIDTH-1:0] signal_remote_col_i,
   input  logic [IDX_W-1:0]          signal_remote_idx_i,
   input  logic                      signal_state_i,
   input  logic                      signal_valid_i,
   output logic                      signal_ready_o,
   output logic [STREAM_WIDTH-1:0]   msg_data_o,
   output logic [1:0]                msg_dir_o,
   output logic                      msg_valid_o,
   input  logic                      msg_ready_i,
   output logic                      self_drop_o,
   output logic                      idle_o
);

   localparam int c_PAYLOAD_W  = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - 1 - COMMAND_WIDTH;
   localparam int c_INSTR_PAD  = c_PAYLOAD_W - 1 - INSTR_WIDTH;
   localparam int c_MAP_PAD    = c_PAYLOAD_W - (IO_W + 1 + ADDR_ROW_WIDTH + ADDR_COL_WIDTH + IDX_W + 3);
   localparam int c_SIG_PAD    = c_PAYLOAD_W - (ADDR_ROW_WIDTH + ADDR_COL_WIDTH + IDX_W + 1);

   localparam logic [COMMAND_WIDTH-1:0] c_CMD_LOAD_INSTR = 2'd0;
   localparam logic [COMMAND_WIDTH-1:0] c_CMD_MAP_IO     = 2'd1;
   localparam logic [COMMAND_WIDTH-1:0] c_CMD_SIG_STATE  = 2'd2;

   localparam logic [1:0] c_DIR_N = 2'd0;
   localparam logic [1:0] c_DIR_E = 2'd1;
   localparam logic [1:0] c_DIR_S = 2'd2;
   localparam logic [1:0] c_DIR_W = 2'd3;

   // FIFO state
   logic [STREAM_WIDTH-1:0] r_mem_data [0:1];
   logic [1:0]              r_mem_dir  [0:1];
   logic                    r_wr_ptr;
   logic                    r_rd_ptr;
   logic [1:0]              r_count;
   logic                    r_self_drop;

   logic                     w_full;
   logic                     w_any_valid;
   logic                     w_accept;
   logic                     w_self;
   logic                     w_push;
   logic                     w_pop;
   logic [1:0]               w_dir;
   logic [COMMAND_WIDTH-1:0] w_cmd;
   logic [c_PAYLOAD_W-1:0]   w_payload;
   logic [STREAM_WIDTH-1:0]  w_msg;

   assign w_full      = (r_count == 2'd2);
   assign w_any_valid = signal_valid_i | map_valid_i | instr_valid_i;
   assign w_self      = (tgt_row_i == node_row_i) && (tgt_col_i == node_col_i);
   // Readies are forced low during reset so nothing is accepted that cycle.
   assign w_accept    = w_any_valid && !w_full && !rst_i;
   assign w_push      = w_accept && !w_self;
   assign w_pop       = (r_count != 2'd0) && msg_ready_i;

   assign signal_ready_o = !rst_i && !w_full;
   assign map_ready_o    = !rst_i && !w_full && !signal_valid_i;
   assign instr_ready_o  = !rst_i && !w_full && !signal_valid_i && !map_valid_i;

   // XY routing: resolve column first, then row.
   always_comb begin
      w_dir = c_DIR_N;
      if (tgt_col_i > node_col_i)      w_dir = c_DIR_E;
      else if (tgt_col_i < node_col_i) w_dir = c_DIR_W;
      else if (tgt_row_i > node_row_i) w_dir = c_DIR_S;
      else                             w_dir = c_DIR_N;
   end

   // Pack the highest-priority pending request (signal > map > instr).
   always_comb begin
      w_cmd     = c_CMD_LOAD_INSTR;
      w_payload = {instr_core_i, {c_INSTR_PAD{1'b0}}, instr_data_i};
      if (signal_valid_i) begin
         w_cmd     = c_CMD_SIG_STATE;
         w_payload = {signal_remote_row_i, signal_remote_col_i, signal_remote_idx_i,
                      signal_state_i, {c_SIG_PAD{1'b0}}};
      end else if (map_valid_i) begin
         w_cmd     = c_CMD_MAP_IO;
         w_payload = {map_io_i, map_input_i, map_remote_row_i, map_remote_col_i,
                      map_remote_idx_i, map_slot_i, map_broadcast_i, map_seq_i,
                      {c_MAP_PAD{1'b0}}};
      end
   end

   // Broadcast bit is always clear for messages produced here.
   assign w_msg = {tgt_row_i, tgt_col_i, 1'b0, w_cmd, w_payload};

   // Two-entry FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_mem_data[i] <= '0;
            r_mem_dir[i]  <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_msg;
            r_mem_dir[r_wr_ptr]  <= w_dir;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // One-cycle pulse for accepted requests addressed to this node.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_self_drop <= 1'b0;
      end else begin
         r_self_drop <= w_accept && w_self;
      end
   end

   assign msg_valid_o = (r_count != 2'd0);
   assign msg_data_o  = r_mem_data[r_rd_ptr];
   assign msg_dir_o   = r_mem_dir[r_rd_ptr];
   assign self_drop_o = r_self_drop;
   assign idle_o      = (r_count == 2'd0);

endmodule
`default_nettype wire
